// File: rtl/button_event_encoder_pkg.sv
// Shared button indices, one-hot event codes and timing defaults
// for the clock/alarm control path.
package button_event_encoder_pkg;

  localparam int NUM_BTN = 5;
  localparam int HOLD_W  = 16;

  localparam int BTN_U = 4;
  localparam int BTN_D = 3;
  localparam int BTN_R = 2;
  localparam int BTN_L = 1;
  localparam int BTN_C = 0;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

  localparam btn_vec_t EVT_U = 5'b10000;
  localparam btn_vec_t EVT_D = 5'b01000;
  localparam btn_vec_t EVT_R = 5'b00100;
  localparam btn_vec_t EVT_L = 5'b00010;
  localparam btn_vec_t EVT_C = 5'b00001;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY    = 100;
  localparam int DEF_REPEAT_PERIOD   = 20;

  localparam btn_vec_t DEF_REPEAT_MASK = 5'b11000;

  // True when two or more bits of v are set.
  function automatic logic multi_hot(input btn_vec_t v);
    return |(v & (v - btn_vec_t'(1)));
  endfunction

endpackage

// File: rtl/button_event_encoder_debounce_cell.sv
// One button: synchroniser chain, debounce counter and the
// single-cycle flags for the debounced level about to rise or fall.
module btn_debounce_cell #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_200_hz,
  input  logic rst,
  input  logic raw,
  output logic held,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   s;
  logic                   flip;

  assign s    = sync_q[SYNC_STAGES-1];
  assign flip = (s != held) && (cnt == LAST);

  // rise/fall fire in the cycle before held changes, so a press
  // request lands in pending on the same edge that held goes high.
  assign rise = flip && s;
  assign fall = flip && !s;

  // Shift the asynchronous button through the synchroniser chain.
  always_ff @(posedge clk_200_hz or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Count consecutive disagreeing samples; flip the level on the last one.
  always_ff @(posedge clk_200_hz or posedge rst) begin
    if (rst) begin
      held <= 1'b0;
      cnt  <= '0;
    end else if (s == held) begin
      cnt  <= '0;
    end else if (flip) begin
      held <= s;
      cnt  <= '0;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/button_event_encoder.sv
// Pushbutton front end: debounced levels, press and auto-repeat
// requests, and a fixed-priority arbiter emitting one-hot events.
module button_event_encoder
  import button_event_encoder_pkg::*;
#(
  parameter int       SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int       DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int       REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int       REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter btn_vec_t REPEAT_MASK     = DEF_REPEAT_MASK
) (
  input  logic       clk_200_hz,
  input  logic       rst,
  input  logic       en,
  input  logic [4:0] btn_raw,
  output logic [4:0] evt,
  output logic       evt_valid,
  output logic [4:0] held
);

  localparam int PW = $clog2(REPEAT_PERIOD) + 1;

  localparam logic [HOLD_W-1:0] HOLD_MAX = '1;
  localparam logic [HOLD_W-1:0] DELAY_V  = HOLD_W'(REPEAT_DELAY);
  localparam logic [PW-1:0]     PRD_LAST = PW'(REPEAT_PERIOD - 1);

  btn_vec_t rise;
  btn_vec_t fall;
  btn_vec_t held_nxt;
  btn_vec_t rpt_raw;
  btn_vec_t rpt_req;
  btn_vec_t req;
  btn_vec_t pending;
  btn_vec_t grant;
  logic     multi;

  logic [HOLD_W-1:0] hold_cnt [NUM_BTN];
  logic [HOLD_W-1:0] hold_nxt [NUM_BTN];
  logic [PW-1:0]     prd_cnt  [NUM_BTN];
  logic [PW-1:0]     prd_nxt  [NUM_BTN];

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
    btn_debounce_cell #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk_200_hz(clk_200_hz),
      .rst       (rst),
      .raw       (btn_raw[i]),
      .held      (held[i]),
      .rise      (rise[i]),
      .fall      (fall[i])
    );
  end

  // Repeat decisions look at the levels as they will be after this edge.
  assign held_nxt = (held | rise) & ~fall;
  assign multi    = multi_hot(held_nxt);

  // Advance hold age and repeat phase; flag the cycles a repeat is due.
  always_comb begin
    rpt_raw = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      hold_nxt[i] = '0;
      prd_nxt[i]  = '0;
      if (held_nxt[i] && !rise[i]) begin
        if (hold_cnt[i] == HOLD_MAX) begin
          hold_nxt[i] = HOLD_MAX;
        end else begin
          hold_nxt[i] = hold_cnt[i] + HOLD_W'(1);
        end
        if (hold_nxt[i] == DELAY_V) begin
          rpt_raw[i] = 1'b1;
        end else if (hold_cnt[i] >= DELAY_V &&
                     hold_cnt[i] != HOLD_MAX) begin
          if (prd_cnt[i] == PRD_LAST) begin
            rpt_raw[i] = 1'b1;
          end else begin
            prd_nxt[i] = prd_cnt[i] + PW'(1);
          end
        end
      end
    end
  end

  assign rpt_req = rpt_raw & REPEAT_MASK & {NUM_BTN{!multi}};
  assign req     = rise | rpt_req;

  // Pick the single highest-priority pending button.
  always_comb begin
    grant = '0;
    priority case (1'b1)
      pending[BTN_C]: grant = EVT_C;
      pending[BTN_L]: grant = EVT_L;
      pending[BTN_R]: grant = EVT_R;
      pending[BTN_D]: grant = EVT_D;
      pending[BTN_U]: grant = EVT_U;
      default:        grant = '0;
    endcase
  end

  // Hold age and repeat phase registers, independent of en.
  always_ff @(posedge clk_200_hz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        hold_cnt[i] <= '0;
        prd_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        hold_cnt[i] <= hold_nxt[i];
        prd_cnt[i]  <= prd_nxt[i];
      end
    end
  end

  // Record requests and issue the granted one; en low flushes everything.
  always_ff @(posedge clk_200_hz or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      evt       <= '0;
      evt_valid <= 1'b0;
    end else if (!en) begin
      pending   <= '0;
      evt       <= '0;
      evt_valid <= 1'b0;
    end else begin
      pending   <= (pending & ~grant) | req;
      evt       <= grant;
      evt_valid <= |grant;
    end
  end

endmodule

// File: tb/tb_button_event_encoder.sv
// Scoreboard bench for button_event_encoder: directed scenarios
// plus random button/en/rst traffic against a behavioural model.
module tb_button_event_encoder;
  import button_event_encoder_pkg::*;

  localparam btn_vec_t RMASK = DEF_REPEAT_MASK;

  logic     clk_200_hz = 1'b0;
  logic     rst;
  logic     en;
  btn_vec_t btn_raw;
  btn_vec_t evt;
  logic     evt_valid;
  btn_vec_t held;

  button_event_encoder dut (
    .clk_200_hz(clk_200_hz),
    .rst       (rst),
    .en        (en),
    .btn_raw   (btn_raw),
    .evt       (evt),
    .evt_valid (evt_valid),
    .held      (held)
  );

  always #5 clk_200_hz = ~clk_200_hz;

  typedef struct packed {
    int       c;
    btn_vec_t e;
  } ev_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic started  = 1'b0;

  ev_t sb[$];
  ev_t dut_ev[$];
  ev_t mon_e;
  ev_t mon_got;
  btn_vec_t held_seen;

  int       xo[$];
  btn_vec_t xe[$];

  // reference model state
  btn_vec_t m_sq [DEF_SYNC_STAGES];
  btn_vec_t m_held;
  btn_vec_t m_pend;
  int       m_run   [NUM_BTN];
  int       m_since [NUM_BTN];

  task automatic model_step(input btn_vec_t raw, input logic e,
                            input logic r);
    btn_vec_t s, press, rep, grant, old;
    int age;
    ev_t x;
    cyc++;
    if (r) begin
      for (int k = 0; k < DEF_SYNC_STAGES; k++) m_sq[k] = '0;
      m_held = '0;
      m_pend = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        m_run[i]   = 0;
        m_since[i] = cyc;
      end
    end else begin
      s = m_sq[DEF_SYNC_STAGES-1];
      for (int k = DEF_SYNC_STAGES - 1; k > 0; k--) m_sq[k] = m_sq[k-1];
      m_sq[0] = raw;
      press = '0;
      rep   = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (s[i] != m_held[i]) begin
          m_run[i]++;
          if (m_run[i] == DEF_DEBOUNCE_CYCLES) begin
            m_held[i] = s[i];
            m_run[i]  = 0;
            if (s[i]) begin
              press[i]   = 1'b1;
              m_since[i] = cyc;
            end
          end
        end else begin
          m_run[i] = 0;
        end
      end
      for (int i = 0; i < NUM_BTN; i++) begin
        if (RMASK[i] && m_held[i] && !press[i] &&
            $countones(m_held) <= 1) begin
          age = cyc - m_since[i];
          if (age > 65535) age = 65535;
          if (age >= DEF_REPEAT_DELAY &&
              (age - DEF_REPEAT_DELAY) % DEF_REPEAT_PERIOD == 0)
            rep[i] = 1'b1;
        end
      end
      old = m_pend;
      if (e) begin
        grant = '0;
        for (int i = 0; i < NUM_BTN; i++)
          if (old[i] && grant == '0) grant[i] = 1'b1;
        m_pend = (old & ~grant) | press | rep;
        if (grant != '0) begin
          x.c = cyc;
          x.e = grant;
          sb.push_back(x);
        end
      end else begin
        m_pend = '0;
      end
    end
  endtask

  task automatic tick(input btn_vec_t b, input logic e, input logic r);
    @(negedge clk_200_hz);
    btn_raw = b;
    en      = e;
    rst     = r;
    @(posedge clk_200_hz);
    model_step(b, e, r);
    started = 1'b1;
  endtask

  task automatic hold(input btn_vec_t b, input int n);
    for (int k = 0; k < n; k++) tick(b, 1'b1, 1'b0);
  endtask

  task automatic expect_events(input string name, input int base);
    n_checks++;
    if (dut_ev.size() != xo.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d events, want %0d",
               name, dut_ev.size(), xo.size());
    end else begin
      foreach (xo[k]) begin
        n_checks++;
        if (dut_ev[k].c != base + xo[k] || dut_ev[k].e != xe[k]) begin
          n_fail++;
          $display("FAIL %s_ev%0d: got %b at +%0d, want %b at +%0d",
                   name, k, dut_ev[k].e, dut_ev[k].c - base,
                   xe[k], xo[k]);
        end
      end
    end
    dut_ev.delete();
  endtask

  // Monitor: compare held every cycle, pop the scoreboard on each event.
  always @(posedge clk_200_hz) begin
    #1;
    if (started) begin
      held_seen = held_seen | held;
      n_checks++;
      if (held !== m_held) begin
        n_fail++;
        $display("FAIL held: got %b want %b cycle %0d", held, m_held, cyc);
      end
      if (evt_valid === 1'b1) begin
        mon_e.c = cyc;
        mon_e.e = evt;
        dut_ev.push_back(mon_e);
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL evt_spurious: got %b want none cycle %0d",
                   evt, cyc);
        end else begin
          mon_got = sb.pop_front();
          if (mon_got.c != cyc || mon_got.e !== evt) begin
            n_fail++;
            $display("FAIL evt: got %b cycle %0d want %b cycle %0d",
                     evt, cyc, mon_got.e, mon_got.c);
          end
        end
      end else begin
        n_checks++;
        if (evt !== '0 || (sb.size() != 0 && sb[0].c <= cyc)) begin
          n_fail++;
          $display("FAIL evt_missed: got %b valid %b want %b cycle %0d",
                   evt, evt_valid,
                   (sb.size() != 0) ? sb[0].e : btn_vec_t'(0), cyc);
          if (sb.size() != 0 && sb[0].c <= cyc) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int base;
    btn_vec_t rb, rx;
    logic re, rr;
    rst = 1'b1;
    en = 1'b1;
    btn_raw = '0;
    held_seen = '0;
    for (int k = 0; k < 3; k++) tick('0, 1'b1, 1'b1);
    hold('0, 5);
    dut_ev.delete();

    // single C press
    base = cyc + 1;
    hold(EVT_C, 50);
    hold('0, 30);
    xo = {6};
    xe = {EVT_C};
    expect_events("c_single", base);

    // glitch then bounce on U
    held_seen = '0;
    base = cyc + 1;
    hold(EVT_U, 3);
    hold('0, 5);
    for (int k = 0; k < 10; k++) hold((k % 2 == 0) ? EVT_U : '0, 1);
    hold('0, 20);
    xo.delete();
    xe.delete();
    expect_events("u_glitch", base);
    n_checks++;
    if (held_seen[BTN_U] !== 1'b0) begin
      n_fail++;
      $display("FAIL u_glitch_held: got 1 want 0");
    end

    // U auto-repeat
    base = cyc + 1;
    hold(EVT_U, 200);
    hold('0, 30);
    xo = {6, 106, 126, 146, 166, 186};
    xe = {EVT_U, EVT_U, EVT_U, EVT_U, EVT_U, EVT_U};
    expect_events("u_repeat", base);

    // R does not repeat
    base = cyc + 1;
    hold(EVT_R, 200);
    hold('0, 30);
    xo = {6};
    xe = {EVT_R};
    expect_events("r_norepeat", base);

    // simultaneous R and L
    base = cyc + 1;
    hold(EVT_R | EVT_L, 30);
    hold('0, 30);
    xo = {6, 7};
    xe = {EVT_L, EVT_R};
    expect_events("rl_arb", base);

    // D pressed with en low, en returns while held
    base = cyc + 1;
    for (int k = 0; k < 20; k++) tick(EVT_D, 1'b0, 1'b0);
    hold(EVT_D, 110);
    hold('0, 30);
    xo = {106, 126};
    xe = {EVT_D, EVT_D};
    expect_events("d_en", base);

    // reset in the middle of a U hold
    base = cyc + 1;
    hold(EVT_U, 50);
    tick(EVT_U, 1'b1, 1'b1);
    tick(EVT_U, 1'b1, 1'b1);
    xo = {6};
    xe = {EVT_U};
    expect_events("u_prerst", base);
    base = cyc + 1;
    hold(EVT_U, 30);
    hold('0, 30);
    xo = {6};
    xe = {EVT_U};
    expect_events("u_postrst", base);

    // random traffic
    rb = '0;
    re = 1'b1;
    for (int k = 0; k < 2500; k++) begin
      for (int b = 0; b < NUM_BTN; b++)
        if ($urandom_range(0, rb[b] ? 150 : 40) == 0) rb[b] = ~rb[b];
      if ($urandom_range(0, 199) == 0) re = ~re;
      rx = rb;
      if ($urandom_range(0, 24) == 0)
        rx = rb ^ (btn_vec_t'(1) << $urandom_range(0, 4));
      rr = ($urandom_range(0, 799) == 0);
      tick(rx, re, rr);
    end
    hold('0, 30);

    #2;
    started = 1'b0;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d left want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
